mem_unit: RTL and testbench

Memory responder on the far side of the CPU bus: it answers the CPU's `pc` with an instruction word and its `addr`/`write` requests with data reads and writes. After reset it holds the CPU in reset while a byte-serial loader fills instruction memory, then releases the CPU. It sits between the top level and the `cpu` block, driving `instruction`, `data` and the CPU `reset`.

---
 rtl/mem_unit.sv | 152 +++++++++++++++
 tb/tb_mem_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_unit.sv
// mem_unit: memory responder for the CPU bus.
//
// After reset a byte-serial loader fills instruction memory while the CPU is
// held in reset. Once the announced number of words has been received the
// block enters RUN, releases the CPU and serves registered instruction and
// data reads plus data writes.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   pc                CPU instruction address (low ADDR_W bits used)
//   addr, wdata       CPU data address and write data
//   write             CPU data write strobe (honoured only in RUN)
//   instruction, data registered read results (0 outside RUN)
//   cpu_reset         high until the load completes
//   load_valid/byte   loader byte stream
//   load_ready        high while the loader still accepts bytes
module mem_unit #(
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] pc,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   input  logic        write,
   output logic [15:0] instruction,
   output logic [15:0] data,
   output logic        cpu_reset,
   input  logic        load_valid,
   input  logic [7:0]  load_byte,
   output logic        load_ready
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {LEN_HI, LEN_LO, WORD_HI, WORD_LO, RUN} state_t;

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] wp_q, wp_d;
   logic [15:0] remain_q, remain_d;
   logic [7:0]  hiByte_q, hiByte_d;
   logic [15:0] instruction_q, data_q;

   logic [15:0] imem [DEPTH];
   logic [15:0] dmem [DEPTH];

   logic inRun;
   logic accept;
   logic imemWe;
   logic dmemWe;

   // Upper address bits alias away and the low length byte is only kept for
   // visibility; collecting them here keeps them deliberately unconsumed.
   logic unusedBits;
   assign unusedBits = ^{pc[15:ADDR_W], addr[15:ADDR_W], wp_q[15:ADDR_W], len_q[7:0]};

   // Loader state register; reset always restarts the load sequence.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LEN_HI;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: advance one step per accepted byte. The length test in
   // LEN_LO uses the incoming byte directly so a zero length skips straight to
   // RUN, and WORD_LO finishes when the last outstanding word arrives.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LEN_HI:  if (accept) state_d = LEN_LO;
         LEN_LO:  if (accept) state_d = ({len_q[15:8], load_byte} == 16'd0) ? RUN : WORD_HI;
         WORD_HI: if (accept) state_d = WORD_LO;
         WORD_LO: if (accept) state_d = (remain_q == 16'd1) ? RUN : WORD_HI;
         RUN:     state_d = RUN;
         default: state_d = LEN_HI;
      endcase
   end

   // Output / strobe logic derived from the current state only.
   always_comb begin
      inRun      = (state_q == RUN);
      load_ready = !inRun;
      cpu_reset  = !inRun;
      accept     = load_valid && !inRun;
      imemWe     = accept && (state_q == WORD_LO);
      dmemWe     = write && inRun;
   end

   // Loader datapath next values: length bytes, word pointer, remaining word
   // count and the latched high byte of the word in flight.
   always_comb begin
      len_d    = len_q;
      wp_d     = wp_q;
      remain_d = remain_q;
      hiByte_d = hiByte_q;
      if (accept) begin
         case (state_q)
            LEN_HI: len_d[15:8] = load_byte;
            LEN_LO: begin
               len_d[7:0] = load_byte;
               wp_d       = 16'd0;
               remain_d   = {len_q[15:8], load_byte};
            end
            WORD_HI: hiByte_d = load_byte;
            WORD_LO: begin
               wp_d     = wp_q + 16'd1;
               remain_d = remain_q - 16'd1;
            end
            default: ;
         endcase
      end
   end

   // Loader registers and registered read ports. Reads are forced to zero
   // outside RUN so the CPU never sees a half-loaded image.
   always_ff @(posedge clk) begin
      if (reset) begin
         len_q         <= 16'd0;
         wp_q          <= 16'd0;
         remain_q      <= 16'd0;
         hiByte_q      <= 8'd0;
         instruction_q <= 16'd0;
         data_q        <= 16'd0;
      end else begin
         len_q         <= len_d;
         wp_q          <= wp_d;
         remain_q      <= remain_d;
         hiByte_q      <= hiByte_d;
         instruction_q <= inRun ? imem[pc[ADDR_W-1:0]] : 16'd0;
         data_q        <= inRun ? dmem[addr[ADDR_W-1:0]] : 16'd0;
      end
   end

   // Memory arrays are never cleared. Reset suppresses writes so a reset edge
   // coinciding with a loader byte or CPU write leaves memory untouched. The
   // data read above samples the old contents, giving read-first behaviour.
   always_ff @(posedge clk) begin
      if (!reset && imemWe) begin
         imem[wp_q[ADDR_W-1:0]] <= {hiByte_q, load_byte};
      end
      if (!reset && dmemWe) begin
         dmem[addr[ADDR_W-1:0]] <= wdata;
      end
   end

   assign instruction = instruction_q;
   assign data        = data_q;

endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: scoreboard testbench for mem_unit.
//
// A reference model keeps plain arrays of the instruction and data memories.
// Stimulus pushes the expected read result into a queue when a read is
// issued; a monitor pops and compares one cycle later when the result is
// presented. Loader sequencing and reset behaviour are checked directly.
module tb_mem_unit;

   logic        clk;
   logic        reset;
   logic [15:0] pc;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        write;
   logic [15:0] instruction;
   logic [15:0] data;
   logic        cpu_reset;
   logic        load_valid;
   logic [7:0]  load_byte;
   logic        load_ready;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] dat;
      bit          chkI;
      bit          chkD;
   } exp_t;

   exp_t        sbQ[$];
   logic [15:0] imemModel [256];
   bit          imemKnown [256];
   logic [15:0] dmemModel [256];
   bit          dmemKnown [256];
   logic [15:0] loadWords[$];

   int   passCount;
   int   checkCount;
   int   acceptCount;
   logic rdIssue;
   logic rdValid;

   mem_unit #(.ADDR_W(8)) dut (
      .clk(clk),
      .reset(reset),
      .pc(pc),
      .addr(addr),
      .wdata(wdata),
      .write(write),
      .instruction(instruction),
      .data(data),
      .cpu_reset(cpu_reset),
      .load_valid(load_valid),
      .load_byte(load_byte),
      .load_ready(load_ready)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Read results appear one edge after issue; track that with a delayed flag.
   always @(posedge clk) begin
      rdValid <= rdIssue;
   end

   // Count bytes the DUT actually takes from the loader stream.
   always @(posedge clk) begin
      if (load_valid && load_ready && !reset) acceptCount++;
   end

   // Monitor: compare each presented read result with the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (rdValid) begin
         if (sbQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboardEmpty: got read result expected queued entry");
         end else begin
            e = sbQ.pop_front();
            if (e.chkI) checkOutput("instrRead", instruction, e.instr);
            if (e.chkD) checkOutput("dataRead", data, e.dat);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
   endtask

   // One read (and optional write) cycle in RUN; expected values come from the
   // model before the write is applied, which is the read-first rule.
   task automatic applyStimulus(input logic [15:0] pcV, input logic [15:0] addrV,
                                input bit doWrite, input logic [15:0] wdV);
      exp_t e;
      e.instr = imemModel[pcV[7:0]];
      e.chkI  = imemKnown[pcV[7:0]];
      e.dat   = dmemModel[addrV[7:0]];
      e.chkD  = dmemKnown[addrV[7:0]];
      sbQ.push_back(e);
      if (doWrite) begin
         dmemModel[addrV[7:0]] = wdV;
         dmemKnown[addrV[7:0]] = 1'b1;
      end
      pc      = pcV;
      addr    = addrV;
      write   = doWrite;
      wdata   = wdV;
      rdIssue = 1'b1;
      @(negedge clk);
      write   = 1'b0;
      rdIssue = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b);
      load_valid = 1'b1;
      load_byte  = b;
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_instr"}, instruction, 16'h0000);
      checkOutput({tag, "_data"}, data, 16'h0000);
      checkOutput({tag, "_cpuReset"}, {15'd0, cpu_reset}, 16'd1);
      checkOutput({tag, "_loadReady"}, {15'd0, load_ready}, 16'd1);
   endtask

   task automatic doReset();
      reset      = 1'b1;
      load_valid = 1'b0;
      write      = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      checkIdle("reset");
   endtask

   // Stream a full image: length then loadWords. The model simply places word
   // i at address i modulo 256, so later words overwrite earlier ones.
   task automatic loadImage(input logic [15:0] len);
      logic [7:0] bq[$];
      bq.push_back(len[15:8]);
      bq.push_back(len[7:0]);
      for (int i = 0; i < int'(len); i++) begin
         bq.push_back(loadWords[i][15:8]);
         bq.push_back(loadWords[i][7:0]);
      end
      for (int i = 0; i < bq.size(); i++) begin
         if (i == bq.size() - 1)
            checkOutput("cpuResetBeforeLast", {15'd0, cpu_reset}, 16'd1);
         sendByte(bq[i]);
      end
      for (int i = 0; i < int'(len); i++) begin
         imemModel[i % 256] = loadWords[i];
         imemKnown[i % 256] = 1'b1;
      end
      checkOutput("cpuResetAfterLoad", {15'd0, cpu_reset}, 16'd0);
      checkOutput("loadReadyAfterLoad", {15'd0, load_ready}, 16'd0);
      checkOutput("firstRunInstr", instruction, 16'h0000);
   endtask

   // Main stimulus sequence.
   initial begin
      logic [7:0]  stallBytes[$];
      logic [15:0] pcV, addrV, wdV;
      bit          doWrite;

      passCount = 0; checkCount = 0; acceptCount = 0;
      reset = 1'b0; pc = 16'd0; addr = 16'd0; wdata = 16'd0; write = 1'b0;
      load_valid = 1'b0; load_byte = 8'd0; rdIssue = 1'b0;
      for (int i = 0; i < 256; i++) begin
         imemKnown[i] = 1'b0; dmemKnown[i] = 1'b0;
         imemModel[i] = 16'd0; dmemModel[i] = 16'd0;
      end
      @(negedge clk);
      doReset();

      // Two-word image, then read both words back.
      loadWords = {16'h1234, 16'hABCD};
      loadImage(16'd2);
      applyStimulus(16'h0001, 16'h0000, 1'b0, 16'h0000);
      applyStimulus(16'h0000, 16'h0000, 1'b0, 16'h0000);

      // Data write then aliased read, then same-address read-during-write.
      applyStimulus(16'h0001, 16'h0005, 1'b1, 16'hBEEF);
      applyStimulus(16'h0000, 16'h0105, 1'b0, 16'h0000);
      applyStimulus(16'h0000, 16'h0007, 1'b1, 16'h1111);
      applyStimulus(16'h0000, 16'h0007, 1'b1, 16'h2222);
      applyStimulus(16'h0000, 16'h0007, 1'b0, 16'h0000);

      // Zero-length load leaves instruction memory untouched.
      doReset();
      loadWords.delete();
      loadImage(16'd0);
      applyStimulus(16'h0100, 16'h0105, 1'b0, 16'h0000);
      applyStimulus(16'hFF01, 16'h0007, 1'b0, 16'h0000);

      // Length larger than the memory depth wraps around.
      doReset();
      loadWords.delete();
      for (int i = 0; i < 258; i++) loadWords.push_back(16'($urandom));
      loadImage(16'h0102);
      applyStimulus(16'h0000, 16'h0005, 1'b0, 16'h0000);
      applyStimulus(16'h0001, 16'h0005, 1'b0, 16'h0000);
      applyStimulus(16'h00FF, 16'h0005, 1'b0, 16'h0000);

      // Stalled loader with bubbles, then bytes offered in RUN are ignored.
      doReset();
      acceptCount = 0;
      stallBytes = {8'h00, 8'h01, 8'h55, 8'hAA};
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b0;
         load_byte  = 8'($urandom);
         @(negedge clk);
         sendByte(stallBytes[i]);
      end
      imemModel[0] = 16'h55AA;
      checkOutput("stallCpuReset", {15'd0, cpu_reset}, 16'd0);
      for (int i = 0; i < 3; i++) sendByte(8'($urandom));
      checkOutput("acceptCount", 16'(acceptCount), 16'd4);
      applyStimulus(16'h0000, 16'h0000, 1'b0, 16'h0000);
      applyStimulus(16'h0001, 16'h0000, 1'b0, 16'h0000);

      // Reset in the middle of a three-word load, then a fresh one-word load.
      doReset();
      loadWords = {16'h7788};
      stallBytes = {8'h00, 8'h03, 8'h99, 8'h11, 8'h22};
      for (int i = 0; i < 5; i++) sendByte(stallBytes[i]);
      imemModel[0] = 16'h9911;
      doReset();
      loadImage(16'd1);
      applyStimulus(16'h0000, 16'h0000, 1'b0, 16'h0000);
      applyStimulus(16'h0001, 16'h0000, 1'b0, 16'h0000);
      applyStimulus(16'h0002, 16'h0000, 1'b0, 16'h0000);

      // Randomised reads and writes in RUN with random upper address bits.
      for (int i = 0; i < 150; i++) begin
         pcV        = 16'($urandom);
         addrV      = 16'($urandom);
         addrV[7:0] = 8'($urandom_range(0, 15));
         doWrite    = 1'($urandom_range(0, 1));
         wdV        = 16'($urandom);
         applyStimulus(pcV, addrV, doWrite, wdV);
      end

      // Reset coinciding with a write and a loader byte: reset wins.
      reset      = 1'b1;
      write      = 1'b1;
      addr       = 16'h0005;
      wdata      = 16'hDEAD;
      load_valid = 1'b1;
      load_byte  = 8'h00;
      @(negedge clk);
      reset = 1'b0; write = 1'b0; load_valid = 1'b0;
      checkIdle("resetCollision");
      loadWords.delete();
      loadImage(16'd0);
      applyStimulus(16'h0000, 16'h0005, 1'b0, 16'h0000);
      applyStimulus(16'h0000, 16'h0007, 1'b0, 16'h0000);

      // Let the monitor drain outstanding reads, bounded.
      for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(negedge clk);
      if (sbQ.size() > 0) begin
         checkCount++;
         $display("[TB] FAIL scoreboardDrain: got %0d pending expected 0", sbQ.size());
      end
      @(negedge clk);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
